// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register bank.
//   state_t     : controller FSM state encoding
//   SYNC_STAGES : depth of the clock-domain synchronizers
package i2c_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    AWAIT_PTR  = 2'd1,
    WRITE_DATA = 2'd2,
    READ_DATA  = 2'd3
  } state_t;

endpackage

// File: rtl/toggle_sync.sv
// Brings an asynchronous toggle signal into the clk domain and turns each
// level change into a single-cycle event.
//   clk    : destination clock
//   rst_n  : asynchronous active-low reset, clears every flop
//   toggle : asynchronous toggle input
//   pulse  : one-clk event, high while stage 2 and stage 3 disagree
module toggle_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic toggle,
  output logic pulse
);

  // sync[0..SYNC_STAGES-1] are the metastability stages; sync[SYNC_STAGES]
  // holds the previous synchronized level for edge detection.
  logic [SYNC_STAGES:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-1:0], toggle};
    end
  end

  assign pulse = sync[SYNC_STAGES] ^ sync[SYNC_STAGES-1];

endmodule

// File: rtl/i2c_reg_bank.sv
// Register bank behind an I2C target front end. The bus side writes through
// an auto-incrementing pointer (first byte after a write START is the
// pointer); the bus side reads through tx_byte. A local host port has
// direct random access.
//   clk, rst_n          : clock, asynchronous active-low reset
//   rx_byte, rx_toggle  : received byte and its per-byte toggle
//   start_toggle, rw    : START toggle and bus direction (1 = read)
//   tx_ack_toggle       : toggles when tx_byte has been shifted out
//   tx_byte             : registered regs[ptr] for the next read slot
//   host_addr/we/wdata  : local write port
//   host_rdata          : combinational read of regs[host_addr]
//   bus_wr_strobe/addr/data : one-clk report of each bus write
//
// state      | meaning
// -----------+---------------------------------------------------
// IDLE       | no transaction since reset; rx/tx_ack ignored
// AWAIT_PTR  | write START seen; next rx byte loads the pointer
// WRITE_DATA | each rx byte writes regs[ptr], then ptr++
// READ_DATA  | tx_byte follows regs[ptr]; each tx_ack does ptr++
module i2c_reg_bank
  import i2c_pkg::*;
#(
  parameter int         NUM_REGS  = 16,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  rx_byte,
  input  logic                        rx_toggle,
  input  logic                        start_toggle,
  input  logic                        rw,
  input  logic                        tx_ack_toggle,
  output logic [7:0]                  tx_byte,
  input  logic [$clog2(NUM_REGS)-1:0] host_addr,
  input  logic                        host_we,
  input  logic [7:0]                  host_wdata,
  output logic [7:0]                  host_rdata,
  output logic                        bus_wr_strobe,
  output logic [$clog2(NUM_REGS)-1:0] bus_wr_addr,
  output logic [7:0]                  bus_wr_data
);

  localparam int AW = $clog2(NUM_REGS);

  logic rx_evt;
  logic start_evt;
  logic tx_evt;
  logic [SYNC_STAGES-1:0] rw_sync;
  logic rw_s;

  state_t state;
  state_t ent_state;
  state_t state_nxt;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_nxt;
  logic          bus_we;
  logic [7:0]    regs [NUM_REGS];

  toggle_sync u_rx_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .toggle (rx_toggle),
    .pulse  (rx_evt)
  );

  toggle_sync u_start_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .toggle (start_toggle),
    .pulse  (start_evt)
  );

  toggle_sync u_tx_ack_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .toggle (tx_ack_toggle),
    .pulse  (tx_evt)
  );

  // rw is a level, so it only needs the plain synchronizer; it is stable
  // well before the START toggle that makes it relevant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_sync <= '0;
    end else begin
      rw_sync <= {rw_sync[SYNC_STAGES-2:0], rw};
    end
  end

  assign rw_s = rw_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // A START is applied before anything else in the same clk, so a byte
  // arriving together with it is interpreted in the post-START state.
  always_comb begin
    ent_state = state;
    state_nxt = state;
    ptr_nxt   = ptr;
    bus_we    = 1'b0;

    if (start_evt) begin
      ent_state = rw_s ? READ_DATA : AWAIT_PTR;
    end
    state_nxt = ent_state;

    unique case (ent_state)
      AWAIT_PTR: begin
        if (rx_evt) begin
          ptr_nxt   = rx_byte[AW-1:0];
          state_nxt = WRITE_DATA;
        end
      end
      WRITE_DATA: begin
        if (rx_evt) begin
          bus_we  = 1'b1;
          ptr_nxt = AW'(ptr + 1'b1);
        end
      end
      READ_DATA: begin
        if (tx_evt) begin
          ptr_nxt = AW'(ptr + 1'b1);
        end
      end
      default: begin
      end
    endcase
  end

  // The bus write is issued after the host write so that, on an address
  // collision, the later non-blocking assignment (the bus) wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VAL;
      end
    end else begin
      if (host_we) begin
        regs[host_addr] <= host_wdata;
      end
      if (bus_we) begin
        regs[ptr] <= rx_byte;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_byte       <= RESET_VAL;
      bus_wr_strobe <= 1'b0;
      bus_wr_addr   <= '0;
      bus_wr_data   <= 8'h00;
    end else begin
      tx_byte       <= regs[ptr];
      bus_wr_strobe <= bus_we;
      if (bus_we) begin
        bus_wr_addr <= ptr;
        bus_wr_data <= rx_byte;
      end
    end
  end

  assign host_rdata = regs[host_addr];

endmodule
